pipelined_fmul: RTL and testbench
=================================

Name: pipelined_fmul

Overview:
- IEEE-754 single-precision floating-point multiplier, s = a × b, with three pipeline stages.
- Supports four rounding modes, subnormal inputs and outputs, and the infinity, zero and NaN special cases.
- Sits in the pipelined FPU datapath beside the pipelined adder and divider. It accepts one operation per enabled clock.

Parameters:
- None. Widths are fixed: 32-bit operands, 8-bit exponent, 23-bit fraction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clrn  input  1  synchronous, active-high reset.
- a  input  32  operand A, IEEE-754 single.
- b  input  32  operand B, IEEE-754 single.
- rm  input  2  rounding mode: 00 nearest-even, 01 toward −inf, 10 toward +inf, 11 toward zero.
- e  input  1  pipeline enable; stage registers load only when e=1.
- s  output  32  product, IEEE-754 single.

Behaviour:
- Pipeline stages:
  - Stage 1 (combinational):
    - Unpack both operands. Hidden bit is 1 for exp≠0; 0 for exp=0, with effective exponent 1.
    - Sign = a[31]^b[31].
    - Exponent sum = ea + eb − 127.
    - Detect inf, NaN and zero on each operand.
    - Form the first half of the 24×24 mantissa product (partial-product reduction).
  - Register 1.
  - Stage 2: complete the 48-bit significand product. Register 2.
  - Stage 3 (combinational from register 2, drives s):
    - Normalize with leading-zero count, shifting left or right as needed.
    - Handle the subnormal/underflow right shift, keeping guard and sticky bits.
    - Round per the registered rm, then pack.
- rm and all special-case flags travel with their data through the registers.
- Latency:
  - Operands and rm sampled at rising edge k (e=1) appear on s after rising edge k+1.
  - Throughput is one result per clock.
- Enable: e=0 freezes both stage registers, so s holds its value. Inputs presented while e=0 are ignored.
- Reset:
  - clrn=1 at a rising edge clears every stage register to 0, regardless of e.
  - The zeroed state decodes to s = 0x00000000.
  - Reset mid-operation discards all in-flight results.
- Rounding:
  - Use guard, round and sticky bits over the full 48-bit product.
  - Nearest-even: ties go to even.
  - Directed modes use the result sign.
  - A carry out of rounding renormalizes, incrementing the exponent.
- Special cases, in priority order:
  - Either operand NaN → 0x7FC00000 (canonical quiet NaN, sign 0).
  - inf × 0 → 0x7FC00000.
  - inf × finite nonzero, or inf × inf → ±inf (sign = XOR).
  - zero × finite → ±0.
- Overflow, when the exponent after rounding is ≥ 255:
  - rm=00 → ±inf.
  - rm=11 → ±0x7F7FFFFF (max finite).
  - rm=01 → −inf if negative, +max finite if positive.
  - rm=10 → +inf if positive, −max finite if negative.
- Underflow:
  - Results below the normal range are denormalized, then rounded. Rounding may carry the result into the smallest normal.
  - Results below half the smallest subnormal round per rm, to ±0 or ±0x00000001.
- No exception flag outputs.

Test Plan:
- Reset, then e=1, rm=00, a=b=0x3FC00000 (1.5) → s=0x40100000 two edges later. Back-to-back vectors emerge one per clock.
- Underflow and subnormals, rm=00:
  - a=b=0x00800000 → s=0x00000000.
  - a=0x00800000, b=0x3F000000 → s=0x00400000.
  - a=0x003FFFFF, b=0x40000000 → s=0x007FFFFE.
- Overflow: a=b=0x7F7FFFFF:
  - rm=00 → s=0x7F800000.
  - rm=11 → 0x7F7FFFFF.
  - With a=0xFF7FFFFF, b=0x7F7FFFFF, rm=10 → 0xFF7FFFFF.
- Specials:
  - 0x7F800000×0x00FFFFFF → 0x7F800000.
  - 0x7F800000×0x00000000 → 0x7FC00000.
  - 0x7FF000FF×0x3F80FF00 → 0x7FC00000.
- Rounding: a=0x3F800001, b=0x3F800001:
  - rm=00 → 0x3F800002.
  - rm=11 → 0x3F800002.
  - rm=10 → 0x3F800003.
  - Negate a with rm=01 → 0xBF800003.
- Control:
  - Hold e=0 for 3 cycles mid-stream → s frozen, and the result sequence resumes unchanged.
  - Assert clrn with data in flight → s=0x00000000 on the next edge, with no stale results afterwards.

Source files
------------

// File: rtl/pipelined_fmul.sv
// IEEE-754 single-precision multiplier, s = a * b. Two enabled register stages
// (partial products, full product); normalize/round/pack is combinational on s.
module pipelined_fmul (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    input  logic        e,
    output logic [31:0] s
);

    // ---------------- stage 1: unpack, specials, partial products ----------------
    logic [7:0]         w_ea;
    logic [7:0]         w_eb;
    logic [22:0]        w_fa;
    logic [22:0]        w_fb;
    logic [7:0]         w_ea_eff;
    logic [7:0]         w_eb_eff;
    logic [23:0]        w_ma;
    logic [23:0]        w_mb;
    logic               w_a_inf;
    logic               w_a_nan;
    logic               w_a_zero;
    logic               w_b_inf;
    logic               w_b_nan;
    logic               w_b_zero;
    logic               w_nan;
    logic               w_inf;
    logic               w_zero;
    logic               w_sign;
    logic signed [10:0] w_exp_sum;
    logic [35:0]        w_pp_lo;
    logic [35:0]        w_pp_hi;

    assign w_ea     = a[30:23];
    assign w_eb     = b[30:23];
    assign w_fa     = a[22:0];
    assign w_fb     = b[22:0];
    assign w_ea_eff = (w_ea == 8'd0) ? 8'd1 : w_ea;
    assign w_eb_eff = (w_eb == 8'd0) ? 8'd1 : w_eb;
    assign w_ma     = {|w_ea, w_fa};
    assign w_mb     = {|w_eb, w_fb};

    assign w_a_inf  = (&w_ea) & ~(|w_fa);
    assign w_a_nan  = (&w_ea) &  (|w_fa);
    assign w_a_zero = ~(|w_ea) & ~(|w_fa);
    assign w_b_inf  = (&w_eb) & ~(|w_fb);
    assign w_b_nan  = (&w_eb) &  (|w_fb);
    assign w_b_zero = ~(|w_eb) & ~(|w_fb);

    // inf * 0 is folded into the NaN flag so later stages see a clean priority.
    assign w_nan  = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    assign w_inf  = w_a_inf | w_b_inf;
    assign w_zero = w_a_zero | w_b_zero;
    assign w_sign = a[31] ^ b[31];

    assign w_exp_sum = $signed({3'd0, w_ea_eff}) + $signed({3'd0, w_eb_eff}) - 11'sd127;

    assign w_pp_lo = {12'd0, w_ma} * {24'd0, w_mb[11:0]};
    assign w_pp_hi = {12'd0, w_ma} * {24'd0, w_mb[23:12]};

    logic               r_s1_sign;
    logic signed [10:0] r_s1_exp;
    logic [1:0]         r_s1_rm;
    logic               r_s1_nan;
    logic               r_s1_inf;
    logic               r_s1_zero;
    logic [35:0]        r_s1_pp_lo;
    logic [35:0]        r_s1_pp_hi;

    always_ff @(posedge clk) begin
        if (clrn) begin
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_rm    <= 2'd0;
            r_s1_nan   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_pp_lo <= '0;
            r_s1_pp_hi <= '0;
        end else if (e) begin
            r_s1_sign  <= w_sign;
            r_s1_exp   <= w_exp_sum;
            r_s1_rm    <= rm;
            r_s1_nan   <= w_nan;
            r_s1_inf   <= w_inf;
            r_s1_zero  <= w_zero;
            r_s1_pp_lo <= w_pp_lo;
            r_s1_pp_hi <= w_pp_hi;
        end
    end

    // ---------------- stage 2: finish the 48-bit significand product ----------------
    logic [47:0] w_prod;
    assign w_prod = {12'd0, r_s1_pp_lo} + {r_s1_pp_hi, 12'd0};

    logic               r_s2_sign;
    logic signed [10:0] r_s2_exp;
    logic [1:0]         r_s2_rm;
    logic               r_s2_nan;
    logic               r_s2_inf;
    logic               r_s2_zero;
    logic [47:0]        r_s2_prod;

    always_ff @(posedge clk) begin
        if (clrn) begin
            r_s2_sign <= 1'b0;
            r_s2_exp  <= '0;
            r_s2_rm   <= 2'd0;
            r_s2_nan  <= 1'b0;
            r_s2_inf  <= 1'b0;
            r_s2_zero <= 1'b0;
            r_s2_prod <= '0;
        end else if (e) begin
            r_s2_sign <= r_s1_sign;
            r_s2_exp  <= r_s1_exp;
            r_s2_rm   <= r_s1_rm;
            r_s2_nan  <= r_s1_nan;
            r_s2_inf  <= r_s1_inf;
            r_s2_zero <= r_s1_zero;
            r_s2_prod <= w_prod;
        end
    end

    // ---------------- stage 3: normalize, denormalize, round, pack ----------------
    logic [5:0]         w_lz;
    logic [47:0]        w_norm;
    logic signed [11:0] w_exp_n;
    logic [5:0]         w_rsh;
    logic [9:0]         w_exp_f;
    logic [97:0]        w_wide;
    logic [23:0]        w_mant;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inc;
    logic [32:0]        w_rounded;
    logic               w_ovf;
    logic               w_to_inf;

    always_comb begin
        w_lz = 6'd47;
        for (int i = 0; i < 48; i++) begin
            if (r_s2_prod[i]) w_lz = 6'(47 - i);
        end
    end

    // After the shift the leading one sits at bit 47, i.e. the value is 1.x * 2^(w_exp_n-127).
    assign w_norm  = r_s2_prod << w_lz;
    assign w_exp_n = $signed({r_s2_exp[10], r_s2_exp}) + 12'sd1 - $signed({6'd0, w_lz});

    // w_exp_f is the packed exponent minus the hidden bit, so adding the 24-bit
    // mantissa (hidden bit included) yields the final field, and a rounding carry
    // naturally bumps the exponent, including subnormal -> smallest normal.
    always_comb begin
        w_rsh   = 6'd0;
        w_exp_f = 10'd0;
        if (w_exp_n < 12'sd1) begin
            if (w_exp_n < -12'sd48) w_rsh = 6'd50;
            else                    w_rsh = 6'(12'sd1 - w_exp_n);
        end else begin
            w_exp_f = 10'(w_exp_n - 12'sd1);
        end
    end

    assign w_wide   = {w_norm, 50'd0} >> w_rsh;
    assign w_mant   = w_wide[97:74];
    assign w_guard  = w_wide[73];
    assign w_sticky = |w_wide[72:0];

    always_comb begin
        w_inc = 1'b0;
        case (r_s2_rm)
            2'b00:   w_inc = w_guard & (w_sticky | w_mant[0]);
            2'b01:   w_inc = (w_guard | w_sticky) & r_s2_sign;
            2'b10:   w_inc = (w_guard | w_sticky) & ~r_s2_sign;
            default: w_inc = 1'b0;
        endcase
    end

    assign w_rounded = {w_exp_f, 23'd0} + {9'd0, w_mant} + {32'd0, w_inc};
    assign w_ovf     = (w_rounded[32:23] >= 10'd255);
    assign w_to_inf  = (r_s2_rm == 2'b00) | ((r_s2_rm == 2'b01) & r_s2_sign)
                     | ((r_s2_rm == 2'b10) & ~r_s2_sign);

    always_comb begin
        s = {r_s2_sign, w_rounded[30:0]};
        if (r_s2_nan) begin
            s = 32'h7FC00000;
        end else if (r_s2_inf) begin
            s = {r_s2_sign, 8'hFF, 23'd0};
        end else if (r_s2_zero || (r_s2_prod == 48'd0)) begin
            s = {r_s2_sign, 31'd0};
        end else if (w_ovf) begin
            s = w_to_inf ? {r_s2_sign, 8'hFF, 23'd0} : {r_s2_sign, 8'hFE, 23'h7FFFFF};
        end
    end

endmodule

// File: tb/tb_pipelined_fmul.sv
// Bench for pipelined_fmul: directed corner vectors plus randomized operands
// checked against an exact-integer rounding model through an expected queue.
module tb_pipelined_fmul;

    logic        clk;
    logic        clrn;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic        e;
    logic [31:0] s;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    pipelined_fmul dut (
        .clk  (clk),
        .clrn (clrn),
        .a    (a),
        .b    (b),
        .rm   (rm),
        .e    (e),
        .s    (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Exact model: value = p * 2^e2; pick the ulp exponent u of the result
    // (clamped at the subnormal ulp 2^-149), split p into kept part n and
    // remainder, round by mode, then encode as ((u+149)<<23) + n.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] mode);
        logic   sgn;
        int     ex_x, ex_y, e2, msb, u, k, cmp;
        longint mx, my, p, n, rem, half, enc;
        bit     nan_x, nan_y, inf_x, inf_y, zero_x, zero_y, inexact, inc;
        sgn    = x[31] ^ y[31];
        ex_x   = int'(x[30:23]);
        ex_y   = int'(y[30:23]);
        nan_x  = (ex_x == 255) && (x[22:0] != 0);
        nan_y  = (ex_y == 255) && (y[22:0] != 0);
        inf_x  = (ex_x == 255) && (x[22:0] == 0);
        inf_y  = (ex_y == 255) && (y[22:0] == 0);
        zero_x = (ex_x == 0) && (x[22:0] == 0);
        zero_y = (ex_y == 0) && (y[22:0] == 0);
        if (nan_x || nan_y) return 32'h7FC00000;
        if ((inf_x && zero_y) || (inf_y && zero_x)) return 32'h7FC00000;
        if (inf_x || inf_y) return {sgn, 8'hFF, 23'd0};
        if (zero_x || zero_y) return {sgn, 31'd0};
        mx = (ex_x == 0) ? longint'(x[22:0]) : longint'({1'b1, x[22:0]});
        my = (ex_y == 0) ? longint'(y[22:0]) : longint'({1'b1, y[22:0]});
        if (ex_x == 0) ex_x = 1;
        if (ex_y == 0) ex_y = 1;
        p  = mx * my;
        e2 = ex_x + ex_y - 300;
        msb = 0;
        for (int i = 0; i < 48; i++) if (p[i]) msb = i;
        u = msb + e2 - 23;
        if (u < -149) u = -149;
        k = u - e2;
        if (k <= 0) begin
            n = p << (-k);
            inexact = 0;
            cmp = -1;
        end else if (k > 60) begin
            n = 0;
            inexact = 1;
            cmp = -1;
        end else begin
            n    = p >> k;
            rem  = p - (n << k);
            half = longint'(1) << (k - 1);
            inexact = (rem != 0);
            cmp = (rem > half) ? 1 : ((rem == half) ? 0 : -1);
        end
        case (mode)
            2'b00:   inc = inexact && ((cmp > 0) || ((cmp == 0) && n[0]));
            2'b01:   inc = inexact && sgn;
            2'b10:   inc = inexact && !sgn;
            default: inc = 0;
        endcase
        if (inc) n = n + 1;
        enc = (longint'(u + 149) << 23) + n;
        if (enc >= (longint'(255) << 23)) begin
            if ((mode == 2'b00) || (mode == 2'b01 && sgn) || (mode == 2'b10 && !sgn))
                return {sgn, 8'hFF, 23'd0};
            return {sgn, 8'hFE, 23'h7FFFFF};
        end
        return {sgn, enc[30:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  ex;
        logic [22:0] fr;
        int          cls;
        cls = $urandom_range(0, 9);
        fr  = 23'($urandom);
        if ($urandom_range(0, 5) == 0) fr = 23'd0;
        case (cls)
            0:       ex = 8'd0;
            1:       ex = 8'd255;
            2, 3:    ex = 8'($urandom_range(1, 40));
            4, 5:    ex = 8'($urandom_range(200, 254));
            default: ex = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), ex, fr};
    endfunction

    // One clock: drive at the falling edge, update the expected queue at the
    // rising edge, compare s at the next falling edge.
    task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [1:0] trm, input logic te, input logic trst,
                        input logic [31:0] texp);
        a    = ta;
        b    = tb_;
        rm   = trm;
        e    = te;
        clrn = trst;
        @(posedge clk);
        if (trst) begin
            exp_q.delete();
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
        end else if (te) begin
            exp_q.push_back(texp);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        check_eq(tag, s, exp_q[0]);
    endtask

    logic [31:0] dir_a   [14];
    logic [31:0] dir_b   [14];
    logic [1:0]  dir_rm  [14];
    logic [31:0] dir_exp [14];

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rrm;
        logic        re, rrst;

        dir_a[0]  = 32'h3FC00000; dir_b[0]  = 32'h3FC00000; dir_rm[0]  = 2'd0; dir_exp[0]  = 32'h40100000;
        dir_a[1]  = 32'h00800000; dir_b[1]  = 32'h00800000; dir_rm[1]  = 2'd0; dir_exp[1]  = 32'h00000000;
        dir_a[2]  = 32'h00800000; dir_b[2]  = 32'h3F000000; dir_rm[2]  = 2'd0; dir_exp[2]  = 32'h00400000;
        dir_a[3]  = 32'h003FFFFF; dir_b[3]  = 32'h40000000; dir_rm[3]  = 2'd0; dir_exp[3]  = 32'h007FFFFE;
        dir_a[4]  = 32'h7F7FFFFF; dir_b[4]  = 32'h7F7FFFFF; dir_rm[4]  = 2'd0; dir_exp[4]  = 32'h7F800000;
        dir_a[5]  = 32'h7F7FFFFF; dir_b[5]  = 32'h7F7FFFFF; dir_rm[5]  = 2'd3; dir_exp[5]  = 32'h7F7FFFFF;
        dir_a[6]  = 32'hFF7FFFFF; dir_b[6]  = 32'h7F7FFFFF; dir_rm[6]  = 2'd2; dir_exp[6]  = 32'hFF7FFFFF;
        dir_a[7]  = 32'h7F800000; dir_b[7]  = 32'h00FFFFFF; dir_rm[7]  = 2'd0; dir_exp[7]  = 32'h7F800000;
        dir_a[8]  = 32'h7F800000; dir_b[8]  = 32'h00000000; dir_rm[8]  = 2'd0; dir_exp[8]  = 32'h7FC00000;
        dir_a[9]  = 32'h7FF000FF; dir_b[9]  = 32'h3F80FF00; dir_rm[9]  = 2'd0; dir_exp[9]  = 32'h7FC00000;
        dir_a[10] = 32'h3F800001; dir_b[10] = 32'h3F800001; dir_rm[10] = 2'd0; dir_exp[10] = 32'h3F800002;
        dir_a[11] = 32'h3F800001; dir_b[11] = 32'h3F800001; dir_rm[11] = 2'd3; dir_exp[11] = 32'h3F800002;
        dir_a[12] = 32'h3F800001; dir_b[12] = 32'h3F800001; dir_rm[12] = 2'd2; dir_exp[12] = 32'h3F800003;
        dir_a[13] = 32'hBF800001; dir_b[13] = 32'h3F800001; dir_rm[13] = 2'd1; dir_exp[13] = 32'hBF800003;

        step("reset", 32'h3FC00000, 32'h3FC00000, 2'd0, 1'b1, 1'b1, 32'h0);
        check_eq("reset_zero", s, 32'h00000000);

        for (int i = 0; i < 14; i++)
            step("directed", dir_a[i], dir_b[i], dir_rm[i], 1'b1, 1'b0, dir_exp[i]);

        // Freeze for three cycles with garbage on the inputs, then resume.
        for (int i = 0; i < 3; i++)
            step("freeze", rand_op(), rand_op(), 2'($urandom), 1'b0, 1'b0, 32'h0);
        step("resume", 32'h3FC00000, 32'hC0000000, 2'd0, 1'b1, 1'b0, 32'hC0400000);
        step("resume", 32'h40000000, 32'h40400000, 2'd0, 1'b1, 1'b0, 32'h40C00000);

        // Reset with two results in flight: none of them may surface.
        step("flush_rst", 32'h3F800000, 32'h3F800000, 2'd0, 1'b1, 1'b1, 32'h0);
        step("flush_after", 32'h40000000, 32'h3F800000, 2'd0, 1'b1, 1'b0, 32'h40000000);
        step("flush_after", 32'h40400000, 32'h3F800000, 2'd0, 1'b1, 1'b0, 32'h40400000);
        step("flush_after", 32'h40800000, 32'h3F800000, 2'd0, 1'b1, 1'b0, 32'h40800000);

        for (int i = 0; i < 4000; i++) begin
            ra   = rand_op();
            rb   = rand_op();
            rrm  = 2'($urandom);
            re   = ($urandom_range(0, 9) != 0);
            rrst = ($urandom_range(0, 299) == 0);
            step("random", ra, rb, rrm, re, rrst, ref_mul(ra, rb, rrm));
        end

        for (int i = 0; i < 2; i++)
            step("drain", 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
